// File: rtl/mem_bus_responder_pkg.sv
// Shared types and helpers for the mem_bus_responder picorv32 memory responder.
package mem_bus_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEF_LAT_W = 3;

   // Clamp the solver-chosen latency to the configured ceiling.
   function automatic int sat_lat(input int lat_sel, input int max_latency);
      return (lat_sel > max_latency) ? max_latency : lat_sel;
   endfunction

endpackage

// File: rtl/mem_bus_responder_ram.sv
// Word-addressed 32-bit backing store: asynchronous read port, byte-lane write port.
module mem_bus_responder_ram #(
   parameter int ADDR_BITS = 6
) (
   input  logic                 clk,
   input  logic [ADDR_BITS-1:0] rd_idx,
   output logic [31:0]          rd_data,
   input  logic [ADDR_BITS-1:0] wr_idx,
   input  logic [3:0]           wr_en,
   input  logic [31:0]          wr_data
);

   logic [31:0] mem_q [2**ADDR_BITS];

   assign rd_data = mem_q[rd_idx];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en[i]) begin
            mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// picorv32 native-bus responder with solver-chosen latency and a small backing store.
// Optional immediate assertions are enabled with MEM_BUS_RESPONDER_CHECKS_EN.
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int ADDR_BITS   = 6,
   parameter int MAX_LATENCY = 3,
   parameter int LAT_W       = DEF_LAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_valid,
   input  logic             mem_instr,
   input  logic [31:0]      mem_addr,
   input  logic [31:0]      mem_wdata,
   input  logic [3:0]       mem_wstrb,
   input  logic [LAT_W-1:0] lat_sel,
   output logic             mem_ready,
   output logic [31:0]      mem_rdata,
   output logic             addr_err,
   output logic             protocol_err
);

   // Handshake: the core raises mem_valid and must hold it with stable request
   // fields until mem_ready, which pulses for exactly one cycle per transaction.
   state_t                 state_q, state_d;
   logic [LAT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_BITS-1:0]   idx_q, idx_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [3:0]             wstrb_q, wstrb_d;
   logic                   oor_q, oor_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   perr_q, perr_d;

   logic [ADDR_BITS-1:0]   rd_idx;
   logic [31:0]            rd_word;
   logic [3:0]             wr_en;
   logic [LAT_W-1:0]       lat;
   logic                   req_oor;

   // In IDLE a zero-latency request must read the incoming address directly.
   assign rd_idx  = (state_q == IDLE) ? mem_addr[ADDR_BITS+1:2] : idx_q;
   assign wr_en   = (state_q == RESP && !oor_q) ? wstrb_q : 4'b0000;
   assign req_oor = |mem_addr[31:ADDR_BITS+2];

   mem_bus_responder_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .clk     (clk),
      .rd_idx  (rd_idx),
      .rd_data (rd_word),
      .wr_idx  (idx_q),
      .wr_en   (wr_en),
      .wr_data (wdata_q)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      oor_d   = oor_q;
      rdata_d = rdata_q;
      perr_d  = perr_q;
      lat     = LAT_W'(sat_lat(int'(lat_sel), MAX_LATENCY));
      unique case (state_q)
         IDLE: begin
            if (mem_valid) begin
               idx_d   = mem_addr[ADDR_BITS+1:2];
               wdata_d = mem_wdata;
               wstrb_d = mem_wstrb;
               oor_d   = req_oor;
               if (lat == '0) begin
                  state_d = RESP;
                  rdata_d = req_oor ? 32'h0 : rd_word;
               end else begin
                  cnt_d   = lat;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (!mem_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
               perr_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - LAT_W'(1);
               if (cnt_q == LAT_W'(1)) begin
                  state_d = RESP;
                  rdata_d = oor_q ? 32'h0 : rd_word;
               end
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         oor_q   <= 1'b0;
         rdata_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         oor_q   <= oor_d;
         rdata_q <= rdata_d;
         perr_q  <= perr_d;
      end
   end

   assign mem_ready    = (state_q == RESP);
   assign mem_rdata    = rdata_q;
   assign addr_err     = (state_q == RESP) && oor_q;
   assign protocol_err = perr_q;

`ifdef MEM_BUS_RESPONDER_CHECKS_EN
   logic [31:0] chk_addr_q, chk_wdata_q;
   logic [3:0]  chk_wstrb_q;
   logic        chk_instr_q, chk_ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         chk_addr_q  <= '0;
         chk_wdata_q <= '0;
         chk_wstrb_q <= '0;
         chk_instr_q <= 1'b0;
         chk_ready_q <= 1'b0;
      end else begin
         if (state_q == WAIT && mem_valid) begin
            assert (mem_addr == chk_addr_q);
            assert (mem_wdata == chk_wdata_q);
            assert (mem_wstrb == chk_wstrb_q);
            assert (mem_instr == chk_instr_q);
         end
         assert (!(mem_valid && mem_instr && mem_wstrb != 4'b0000));
         assert (!perr_q);
         assert (!(mem_ready && chk_ready_q));
         chk_addr_q  <= mem_addr;
         chk_wdata_q <= mem_wdata;
         chk_wstrb_q <= mem_wstrb;
         chk_instr_q <= mem_instr;
         chk_ready_q <= mem_ready;
      end
   end
`else
   logic unused_req_bits;
   assign unused_req_bits = ^{mem_instr, mem_addr[1:0]};
`endif

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: randomized traffic against an array reference model.
module tb_mem_bus_responder;

   localparam int ADDR_BITS   = 6;
   localparam int MAX_LATENCY = 3;
   localparam int LAT_W       = 3;
   localparam int DEPTH       = 2**ADDR_BITS;
   localparam int EW          = 65;  // {ready cycle[31:0], addr_err, rdata[31:0]}

   logic             clk = 1'b0;
   logic             reset;
   logic             mem_valid;
   logic             mem_instr;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic [3:0]       mem_wstrb;
   logic [LAT_W-1:0] lat_sel;
   logic             mem_ready;
   logic [31:0]      mem_rdata;
   logic             addr_err;
   logic             protocol_err;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_bus_responder #(
      .ADDR_BITS   (ADDR_BITS),
      .MAX_LATENCY (MAX_LATENCY),
      .LAT_W       (LAT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_valid    (mem_valid),
      .mem_instr    (mem_instr),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb),
      .lat_sel      (lat_sel),
      .mem_ready    (mem_ready),
      .mem_rdata    (mem_rdata),
      .addr_err     (addr_err),
      .protocol_err (protocol_err)
   );

   logic [31:0]   model_mem [DEPTH];
   logic [EW-1:0] exp_q [$];
   logic [EW-1:0] mon_e;
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            at_resp = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response pops one expectation; a response with nothing pending is an error.
   always @(negedge clk) begin
      if (!reset && mem_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ready_cycle", 64'(cyc), 64'(mon_e[64:33]));
            check("rdata", 64'(mem_rdata), 64'(mon_e[31:0]));
            check("addr_err", 64'(addr_err), 64'(mon_e[32]));
         end
      end
      if (!reset && addr_err && !mem_ready) check("addr_err_without_ready", 64'd1, 64'd0);
   end

   task automatic start_req(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [2:0] ls);
      mem_valid = 1'b1;
      mem_addr  = addr;
      mem_wdata = wdata;
      mem_wstrb = wstrb;
      lat_sel   = ls;
      mem_instr = (wstrb == 4'b0000) ? 1'($urandom_range(0, 1)) : 1'b0;
   endtask

   // Full transaction: predict from the reference model, drive, wait for the response.
   task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [2:0] ls);
      int          lat;
      int          idx;
      bit          oor;
      bit          got;
      logic [31:0] exp_rd;
      logic [31:0] exp_cyc;
      lat    = (int'(ls) > MAX_LATENCY) ? MAX_LATENCY : int'(ls);
      oor    = (addr[31:ADDR_BITS+2] != '0);
      idx    = int'(addr[ADDR_BITS+1:2]);
      exp_rd = oor ? 32'h0 : model_mem[idx];
      if (!oor) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
         end
      end
      exp_cyc = 32'(cyc + 32'(lat) + 1 + (at_resp ? 1 : 0));
      exp_q.push_back({exp_cyc, oor, exp_rd});
      start_req(addr, wdata, wstrb, ls);
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = mem_ready;
      end
      if (!got) begin
         check("ready_timeout", 64'd0, 64'd1);
         void'(exp_q.pop_back());
      end
      at_resp = got;
   endtask

   task automatic idle(input int n);
      mem_valid = 1'b0;
      mem_wstrb = 4'b0000;
      mem_instr = 1'b0;
      repeat (n) @(negedge clk);
      at_resp = 1'b0;
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  ws;
      reset     = 1'b1;
      mem_valid = 1'b0;
      mem_instr = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      lat_sel   = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_ready", 64'(mem_ready), 64'd0);
      check("reset_rdata", 64'(mem_rdata), 64'd0);
      check("reset_addr_err", 64'(addr_err), 64'd0);
      check("reset_protocol_err", 64'(protocol_err), 64'd0);

      // Fill the whole store through the bus so the model starts from known contents.
      for (int i = 0; i < DEPTH; i++) begin
         issue(32'(i) << 2, $urandom, 4'hF, 3'($urandom_range(0, 7)));
      end
      idle(1);

      // Directed cases.
      issue(32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 3'd0);
      idle(1);
      issue(32'h0000_000C, 32'h0, 4'h0, 3'd0);
      issue(32'h0000_0004, 32'h1122_3344, 4'hF, 3'd1);
      issue(32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 3'd2);
      issue(32'h0000_0004, 32'h0, 4'h0, 3'd0);
      idle(2);
      issue(32'h0000_0008, 32'h0, 4'h0, 3'd7);
      idle(1);
      issue(32'h0000_0100, 32'h5555_AAAA, 4'hF, 3'd1);
      issue(32'h0000_0100, 32'h0, 4'h0, 3'd0);
      issue(32'h0000_0000, 32'h0, 4'h0, 3'd2);
      idle(1);

      // Early drop: request abandoned in the second cycle of a lat=3 write.
      start_req(32'h0000_0014, 32'hCAFE_F00D, 4'hF, 3'd3);
      @(negedge clk);
      idle(6);
      check("protocol_err_after_drop", 64'(protocol_err), 64'd1);
      issue(32'h0000_0014, 32'h0, 4'h0, 3'd1);
      idle(2);
      check("protocol_err_sticky", 64'(protocol_err), 64'd1);

      // Reset while a lat=3 write is waiting.
      start_req(32'h0000_0018, 32'h1234_5678, 4'hF, 3'd3);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_ready", 64'(mem_ready), 64'd0);
      check("midreset_protocol_err", 64'(protocol_err), 64'd0);
      check("midreset_rdata", 64'(mem_rdata), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      issue(32'h0000_0018, 32'h0, 4'h0, 3'd0);
      idle(1);

      // Randomized traffic: mixed reads/writes, latencies, gaps and out-of-range addresses.
      for (int n = 0; n < 300; n++) begin
         a = $urandom;
         if ($urandom_range(0, 7) != 0) a[31:ADDR_BITS+2] = '0;
         ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         issue(a, $urandom, ws, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(3);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("final_protocol_err", 64'(protocol_err), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
